// File: rtl/pipe_pkg.sv
// Shared constants and state type for the pipe_stage_buf pipeline buffer.
package pipe_pkg;

  localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;

  // Encoding doubles as the held-entry count driven on occ.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_entry.sv
// Load-enabled payload/control register; instruction resets to the bubble word.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int          CTRL_W    = 20,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [15:0]       instr_i,
  input  logic [15:0]       pc_i,
  input  logic [15:0]       imm_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [15:0]       instr_o,
  output logic [15:0]       pc_o,
  output logic [15:0]       imm_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic [15:0]       instr_q, pc_q, imm_q;
  logic [CTRL_W-1:0] ctrl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      imm_q   <= imm_i;
      ctrl_q  <= ctrl_i;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign imm_o   = imm_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// In-order pipeline buffer: 2-entry main+skid with PIPE_STAGE_SKID_EN, else 1 entry.
// EMPTY: nothing held | ONE: main valid | TWO: main valid, skid holds younger entry
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int          CTRL_W    = 20,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [15:0]       in_pc,
  input  logic [15:0]       in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_instr,
  output logic [15:0]       out_pc,
  output logic [15:0]       out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ
);

  state_e state_q, state_d;
  logic   main_load, skid_load;
  logic   accept, consume;

  logic [15:0]       main_instr, main_pc, main_imm;
  logic [CTRL_W-1:0] main_ctrl;
  logic [15:0]       main_instr_d, main_pc_d, main_imm_d;
  logic [CTRL_W-1:0] main_ctrl_d;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_load = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = TWO;
`endif
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

`ifdef PIPE_STAGE_SKID_EN
  logic [15:0]       skid_instr, skid_pc, skid_imm;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              in_ready_q;

  // Registered so in_ready never depends on out_ready within a cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in_ready_q <= 1'b1;
    else      in_ready_q <= (state_d != TWO);
  end
  assign in_ready = in_ready_q;

  always_comb begin
    main_instr_d = in_instr;
    main_pc_d    = in_pc;
    main_imm_d   = in_imm;
    main_ctrl_d  = in_ctrl;
    if (state_q == TWO) begin
      main_instr_d = skid_instr;
      main_pc_d    = skid_pc;
      main_imm_d   = skid_imm;
      main_ctrl_d  = skid_ctrl;
    end
  end

  pipe_entry #(.CTRL_W(CTRL_W), .NOP_INSTR(NOP_INSTR)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .imm_i   (in_imm),
    .ctrl_i  (in_ctrl),
    .instr_o (skid_instr),
    .pc_o    (skid_pc),
    .imm_o   (skid_imm),
    .ctrl_o  (skid_ctrl)
  );
`else
  logic unused_skid_load;
  assign unused_skid_load = skid_load;
  assign in_ready     = !out_valid || out_ready;
  assign main_instr_d = in_instr;
  assign main_pc_d    = in_pc;
  assign main_imm_d   = in_imm;
  assign main_ctrl_d  = in_ctrl;
`endif

  pipe_entry #(.CTRL_W(CTRL_W), .NOP_INSTR(NOP_INSTR)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load),
    .instr_i (main_instr_d),
    .pc_i    (main_pc_d),
    .imm_i   (main_imm_d),
    .ctrl_i  (main_ctrl_d),
    .instr_o (main_instr),
    .pc_o    (main_pc),
    .imm_o   (main_imm),
    .ctrl_o  (main_ctrl)
  );

  assign out_valid = (state_q != EMPTY) && !flush;
  assign out_instr = out_valid ? main_instr : NOP_INSTR;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_pc    = main_pc;
  assign out_imm   = main_imm;
  assign occ       = state_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf against a queue-based reference model.
module tb_pipe_stage_buf;

  localparam int          CTRL_W = 20;
  localparam logic [15:0] NOP    = 16'h0800;

  typedef struct packed {
    logic [15:0]       instr;
    logic [15:0]       pc;
    logic [15:0]       imm;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0]       in_instr, in_pc, in_imm, out_instr, out_pc, out_imm;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [1:0]        occ;

  ent_t        q[$];
  logic [15:0] delivered[$];
  logic [15:0] last_pc, last_imm;
  logic        seen_cccc;
  int          checks, errors;

  pipe_stage_buf #(.CTRL_W(CTRL_W), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_imm(out_imm),
    .out_ctrl(out_ctrl), .occ(occ)
  );

  always #5 clk = ~clk;

  function automatic ent_t rand_ent(input logic [15:0] instr);
    ent_t e;
    e.instr = instr;
    e.pc    = 16'($urandom());
    e.imm   = 16'($urandom());
    e.ctrl  = CTRL_W'($urandom());
    return e;
  endfunction

  task automatic drive(input ent_t e);
    in_instr = e.instr;
    in_pc    = e.pc;
    in_imm   = e.imm;
    in_ctrl  = e.ctrl;
  endtask

  // One clock: compare outputs with the model, then advance both across the edge.
  task automatic step(output logic acc);
    logic              exp_valid, exp_ready, cons;
    logic [15:0]       exp_instr;
    logic [CTRL_W-1:0] exp_ctrl;
    ent_t              cur;
    #2;
    exp_valid = (q.size() > 0) && !flush;
`ifdef PIPE_STAGE_SKID_EN
    exp_ready = (q.size() < 2);
`else
    exp_ready = !exp_valid || out_ready;
`endif
    exp_instr = exp_valid ? q[0].instr : NOP;
    exp_ctrl  = exp_valid ? q[0].ctrl : '0;
    checks += 7;
    if (out_valid !== exp_valid) begin errors++; $display("FAIL out_valid: got %b want %b at %0t", out_valid, exp_valid, $time); end
    if (in_ready !== exp_ready) begin errors++; $display("FAIL in_ready: got %b want %b at %0t", in_ready, exp_ready, $time); end
    if (occ !== 2'(q.size())) begin errors++; $display("FAIL occ: got %0d want %0d at %0t", occ, q.size(), $time); end
    if (out_instr !== exp_instr) begin errors++; $display("FAIL out_instr: got %h want %h at %0t", out_instr, exp_instr, $time); end
    if (out_ctrl !== exp_ctrl) begin errors++; $display("FAIL out_ctrl: got %h want %h at %0t", out_ctrl, exp_ctrl, $time); end
    if (out_pc !== last_pc) begin errors++; $display("FAIL out_pc: got %h want %h at %0t", out_pc, last_pc, $time); end
    if (out_imm !== last_imm) begin errors++; $display("FAIL out_imm: got %h want %h at %0t", out_imm, last_imm, $time); end
    if (out_valid && out_instr == 16'hCCCC) seen_cccc = 1'b1;
    if (out_valid && out_ready) delivered.push_back(out_instr);
    acc  = in_valid && exp_ready;
    cons = exp_valid && out_ready;
    cur  = '{instr: in_instr, pc: in_pc, imm: in_imm, ctrl: in_ctrl};
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(cur);
    end
    if (q.size() > 0) begin
      last_pc  = q[0].pc;
      last_imm = q[0].imm;
    end
    #1;
  endtask

  task automatic send(input ent_t e, input int budget);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    drive(e);
    for (int i = 0; i < budget && !acc; i++) step(acc);
    in_valid = 1'b0;
    checks++;
    if (!acc) begin errors++; $display("FAIL send_timeout: instr %h not accepted after %0d cycles", e.instr, budget); end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  task automatic model_reset();
    q.delete();
    last_pc  = '0;
    last_imm = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(rand_ent(16'h0));
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks += 6;
    if (occ !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occ); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (out_instr !== 16'h0800) begin errors++; $display("FAIL reset_out_instr: got %h want 0800", out_instr); end
    if (out_ctrl !== '0) begin errors++; $display("FAIL reset_out_ctrl: got %h want 0", out_ctrl); end
    if (out_pc !== 16'h0) begin errors++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    logic [15:0] exp[4];
    exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    out_ready = 1'b1;
    delivered.delete();
    for (int i = 0; i < 4; i++) send(rand_ent(exp[i]), 1);
    idle(2);
    checks++;
    if (delivered.size() != 4) begin errors++; $display("FAIL stream_count: got %0d want 4", delivered.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (delivered[i] !== exp[i]) begin errors++; $display("FAIL stream_order[%0d]: got %h want %h", i, delivered[i], exp[i]); end
    end
  endtask

`ifdef PIPE_STAGE_SKID_EN
  task automatic test_backpressure();
    out_ready = 1'b0;
    send(rand_ent(16'hAAAA), 3);
    send(rand_ent(16'hBBBB), 3);
    #1;
    checks += 2;
    if (occ !== 2'd2) begin errors++; $display("FAIL bp_occ: got %0d want 2", occ); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    idle(2);
    delivered.delete();
    out_ready = 1'b1;
    idle(4);
    checks++;
    if (delivered.size() != 2) begin errors++; $display("FAIL bp_count: got %0d want 2", delivered.size()); end
    else begin
      checks += 2;
      if (delivered[0] !== 16'hAAAA) begin errors++; $display("FAIL bp_first: got %h want aaaa", delivered[0]); end
      if (delivered[1] !== 16'hBBBB) begin errors++; $display("FAIL bp_second: got %h want bbbb", delivered[1]); end
    end
  endtask
`else
  task automatic test_no_skid();
    logic acc;
    out_ready = 1'b0;
    send(rand_ent(16'h5151), 3);
    in_valid = 1'b1;
    drive(rand_ent(16'h5252));
    for (int i = 0; i < 3; i++) begin
      #1;
      checks += 2;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL noskid_in_ready: got %b want 0", in_ready); end
      if (occ > 2'd1) begin errors++; $display("FAIL noskid_occ: got %0d want <=1", occ); end
      step(acc);
    end
    delivered.delete();
    out_ready = 1'b1;
    step(acc);
    in_valid = 1'b0;
    idle(2);
    checks++;
    if (delivered.size() != 2 || delivered[0] !== 16'h5151 || delivered[1] !== 16'h5252)
      begin errors++; $display("FAIL noskid_delivery: got %0d entries want 5151,5252", delivered.size()); end
  endtask
`endif

  task automatic test_flush_full();
    logic acc;
    out_ready = 1'b0;
    seen_cccc = 1'b0;
    send(rand_ent(16'hD001), 3);
`ifdef PIPE_STAGE_SKID_EN
    send(rand_ent(16'hD002), 3);
`endif
    flush = 1'b1;
    in_valid = 1'b1;
    drive(rand_ent(16'hCCCC));
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    if (out_instr !== 16'h0800) begin errors++; $display("FAIL flush_out_instr: got %h want 0800", out_instr); end
    step(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (occ !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d want 0", occ); end
    out_ready = 1'b1;
    idle(4);
    checks++;
    if (seen_cccc) begin errors++; $display("FAIL flush_leak: got cccc emitted want none"); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(rand_ent(16'hE0E0), 3);
    #2;
    rst = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid: got %b want 0", out_valid); end
    if (occ !== 2'd0) begin errors++; $display("FAIL async_occ: got %0d want 0", occ); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL async_in_ready: got %b want 1", in_ready); end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_random();
    logic acc;
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      drive(rand_ent(16'($urandom())));
      step(acc);
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(3);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    seen_cccc = 1'b0;
    test_reset();
    test_stream();
`ifdef PIPE_STAGE_SKID_EN
    test_backpressure();
`else
    test_no_skid();
`endif
    test_flush_full();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 The block SHALL have parameter CTRL_W, default 20, giving the width of the packed control bundle.
REQ-002 The block SHALL have parameter NOP_INSTR, default 16'h0800, giving the bubble instruction word.
REQ-003 Port clk, input, 1: the single clock, rising-edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-low.
REQ-005 Port in_valid, input, 1: the upstream stage presents an instruction.
REQ-006 Port in_ready, output, 1: the block accepts on in_valid && in_ready.
REQ-007 Port in_instr, in_pc, in_imm, input, 16 each: the incoming payload.
REQ-008 Port in_ctrl, input, CTRL_W: the incoming packed decode/execute/memory/writeback control.
REQ-009 Port flush, input, 1: branch-taken kill of all held and incoming entries.
REQ-010 Port out_valid, output, 1: the head entry is valid.
REQ-011 Port out_ready, input, 1: downstream consumes on out_valid && out_ready.
REQ-012 Port out_instr, out_pc, out_imm, output, 16 each: the head payload.
REQ-013 Port out_ctrl, output, CTRL_W: the head control bundle.
REQ-014 Port occ, output, 2: number of held entries, 0 to 2.

Function
REQ-015 The block SHALL be a 2-entry in-order pipeline buffer with states EMPTY, ONE and TWO.
REQ-016 Output SHALL always come from the main entry; the skid entry holds only the younger instruction.
REQ-017 in_ready SHALL be registered and equal (state != TWO), with no combinational path from out_ready.
REQ-018 In EMPTY, an accept SHALL load main and move to ONE.
REQ-019 In ONE, accept with consume SHALL reload main and stay in ONE.
REQ-020 In ONE, accept without consume SHALL load skid and move to TWO.
REQ-021 In ONE, consume without accept SHALL move to EMPTY.
REQ-022 In TWO, consume SHALL move skid into main and go to ONE; in_ready SHALL be 0 in TWO.
REQ-023 When flush=1 at a clock edge, the block SHALL go to EMPTY and discard any same-cycle accept, regardless of other inputs.
REQ-024 While flush=1, out_valid SHALL be 0 combinationally, out_instr SHALL be NOP_INSTR and out_ctrl SHALL be 0.
REQ-025 When out_valid=0, out_instr SHALL be NOP_INSTR and out_ctrl SHALL be 0; out_pc and out_imm SHALL hold their last values.
REQ-026 Latency SHALL be 1 cycle from accept to out_valid, and throughput SHALL be 1 per cycle while out_ready=1.
REQ-027 Payload SHALL be passed without modification; the block SHALL perform no arithmetic.

Reset
REQ-028 While rst=0, the block SHALL asynchronously enter EMPTY with occ=0, out_valid=0 and in_ready=1.
REQ-029 On reset, the instruction registers SHALL reset to NOP_INSTR and all other payload and control registers SHALL reset to 0.
REQ-030 A reset asserted mid-transfer SHALL drop held entries; no partial entry SHALL survive reset.

Configuration
REQ-031 With macro PIPE_STAGE_SKID_EN defined, the block SHALL build the 2-entry behaviour of REQ-015 to REQ-022.
REQ-032 Without PIPE_STAGE_SKID_EN, the block SHALL build a single entry: states EMPTY and ONE only, in_ready = !out_valid || out_ready (combinational), occ at most 1, with flush and reset behaviour unchanged.

Structure
REQ-033 Shared package pipe_pkg SHALL hold the NOP_INSTR default constant and the state typedef (EMPTY, ONE, TWO).
REQ-034 One sub-module, pipe_entry, SHALL be provided: a load-enabled payload and control register with async active-low reset; it SHALL be instantiated once for main and once for skid.

Verification
REQ-035 Reset-release check: hold rst=0, then release -> occ=0, in_ready=1, out_valid=0, out_instr=16'h0800, out_ctrl=0.
REQ-036 Streaming check: send 4 instructions (0x1111, 0x2222, 0x3333, 0x4444) with out_ready=1 -> each appears one cycle later, in order, and in_ready stays 1.
REQ-037 Backpressure check: out_ready=0, send 0xAAAA then 0xBBBB -> occ=2 and in_ready=0; raise out_ready -> 0xAAAA then 0xBBBB are delivered with no loss or duplicate.
REQ-038 Flush-when-full check: with occ=2, flush=1 together with in_valid=1 (0xCCCC) -> out_valid=0 and out_instr=16'h0800 that cycle; next cycle occ=0 and 0xCCCC is never emitted.
REQ-039 Async-reset check: assert rst=0 mid-cycle with occ=1 -> out_valid falls before the next clk edge.
REQ-040 No-skid check: build without PIPE_STAGE_SKID_EN, out_ready=0, then send 2 instructions -> second is held off (in_ready=0) and occ never exceeds 1.
